// File: rtl/comp_pkg.sv
// Shared types for the comparator-sharing controller.
//   OP_W        : operand width of the shared comparator
//   cmp_state_t : controller FSM states
//   cmp_flags_t : comparator result flags (op1 vs op2)
//   cmp_eval    : combinational compare of op1 against op2
package comp_pkg;

  localparam int unsigned OP_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    CMP,
    RESP
  } cmp_state_t;

  typedef struct packed {
    logic eq;
    logic neq;
    logic grt;
    logic lss;
  } cmp_flags_t;

  // Both operands are extended to 33 bits so a single signed compare covers the
  // signed and unsigned cases.
  function automatic cmp_flags_t cmp_eval(input logic [OP_W-1:0] op1,
                                          input logic [OP_W-1:0] op2,
                                          input logic            sign);
    cmp_flags_t         f;
    logic signed [OP_W:0] a;
    logic signed [OP_W:0] b;
    a     = {sign & op1[OP_W-1], op1};
    b     = {sign & op2[OP_W-1], op2};
    f.eq  = (op1 == op2);
    f.neq = ~f.eq;
    f.lss = (a < b);
    f.grt = ~f.eq & ~f.lss;
    return f;
  endfunction

endpackage

// File: rtl/comp_32bs.sv
// 32-bit signed/unsigned comparator with a one-cycle registered result.
//   clk          : clock
//   resetn       : synchronous, active-low reset (all flags cleared)
//   op1, op2     : operands
//   sign         : 1 = signed compare, 0 = unsigned
//   eq/neq/grt/lss : registered flags, op1 vs op2
module comp_32bs
  import comp_pkg::*;
(
  input  logic            clk,
  input  logic            resetn,
  input  logic [OP_W-1:0] op1,
  input  logic [OP_W-1:0] op2,
  input  logic            sign,
  output logic            eq,
  output logic            neq,
  output logic            grt,
  output logic            lss
);

  cmp_flags_t flags_q;
  cmp_flags_t flags_d;

  always_comb begin
    flags_d = cmp_eval(op1, op2, sign);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      flags_q <= '0;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign eq  = flags_q.eq;
  assign neq = flags_q.neq;
  assign grt = flags_q.grt;
  assign lss = flags_q.lss;

endmodule

// File: rtl/comp_share_ctrl_rr_arb.sv
// Round-robin arbiter.
//   clk, reset : clock, synchronous active-high reset (pointer -> 0)
//   req        : request vector
//   advance    : grant taken this cycle; pointer moves past the winner
//   grant      : one-hot winner, searched upward from the pointer (mod N_REQ)
//   idx        : encoded winner index
module rr_arb #(
  parameter  int unsigned N_REQ = 4,
  localparam int unsigned ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic             advance,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  idx
);

  logic [ID_W-1:0] ptr_q;
  logic [ID_W-1:0] ptr_d;
  logic            found;
  int unsigned     cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = (32'(ptr_q) + k) % N_REQ;
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = ID_W'(cand);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      ptr_d = (idx == ID_W'(N_REQ - 1)) ? '0 : idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/comp_share_ctrl.sv
// Shares one comp_32bs comparator between N_REQ requesters.
//   clk, reset      : clock, synchronous active-high reset
//   req_valid/ready : per-requester handshake; req_ready is a one-hot grant
//   req_op1/op2     : packed operands, requester i at [32*i +: 32]
//   req_sign        : per-requester signed compare select
//   rsp_valid/ready : shared response handshake
//   rsp_id          : requester owning the response
//   rsp_eq/neq/grt/lss : comparator flags, op1 vs op2
//   busy            : a compare is in flight or awaiting consumption
module comp_share_ctrl
  import comp_pkg::*;
#(
  parameter  int unsigned N_REQ = 4,
  localparam int unsigned ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [N_REQ*OP_W-1:0] req_op1,
  input  logic [N_REQ*OP_W-1:0] req_op2,
  input  logic [N_REQ-1:0]      req_sign,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic                  rsp_eq,
  output logic                  rsp_neq,
  output logic                  rsp_grt,
  output logic                  rsp_lss,
  output logic                  busy
);

  cmp_state_t      state_q, state_d;
  logic [OP_W-1:0] op1_q, op1_d;
  logic [OP_W-1:0] op2_q, op2_d;
  logic            sign_q, sign_d;
  logic [ID_W-1:0] id_q, id_d;

  logic             grant_en;
  logic             advance;
  logic [N_REQ-1:0] arb_grant;
  logic [ID_W-1:0]  arb_idx;

  rr_arb #(.N_REQ(N_REQ)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req_valid),
    .advance (advance),
    .grant   (arb_grant),
    .idx     (arb_idx)
  );

  // Operand regs hold through RESP, so the comparator keeps re-capturing the
  // same inputs and its flags stay stable under backpressure.
  comp_32bs u_cmp (
    .clk    (clk),
    .resetn (~reset),
    .op1    (op1_q),
    .op2    (op2_q),
    .sign   (sign_q),
    .eq     (rsp_eq),
    .neq    (rsp_neq),
    .grt    (rsp_grt),
    .lss    (rsp_lss)
  );

  always_comb begin
    state_d   = state_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    sign_d    = sign_q;
    id_d      = id_q;
    grant_en  = 1'b0;
    rsp_valid = 1'b0;
    unique case (state_q)
      IDLE: grant_en = 1'b1;
      CMP:  state_d  = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          grant_en = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Acceptance is shared by IDLE and a consumed RESP (back-to-back case).
    if (grant_en && (|req_valid)) begin
      op1_d   = req_op1[arb_idx*OP_W +: OP_W];
      op2_d   = req_op2[arb_idx*OP_W +: OP_W];
      sign_d  = req_sign[arb_idx];
      id_d    = arb_idx;
      state_d = CMP;
    end
  end

  assign advance   = grant_en & (|req_valid);
  assign req_ready = grant_en ? arb_grant : '0;
  assign rsp_id    = id_q;
  assign busy      = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op1_q   <= '0;
      op2_q   <= '0;
      sign_q  <= 1'b0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      sign_q  <= sign_d;
      id_q    <= id_d;
    end
  end

endmodule

// File: tb/tb_comp_share_ctrl.sv
module tb_comp_share_ctrl;

  localparam int N = 4;

  logic          clk;
  logic          reset;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [N*32-1:0] req_op1;
  logic [N*32-1:0] req_op2;
  logic [N-1:0]  req_sign;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [1:0]    rsp_id;
  logic          rsp_eq, rsp_neq, rsp_grt, rsp_lss;
  logic          busy;

  int n_cmp = 0;
  int n_err = 0;

  comp_share_ctrl #(.N_REQ(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op1   (req_op1),
    .req_op2   (req_op2),
    .req_sign  (req_sign),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_eq    (rsp_eq),
    .rsp_neq   (rsp_neq),
    .rsp_grt   (rsp_grt),
    .rsp_lss   (rsp_lss),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  // One outstanding job at most; a job becomes a visible response one cycle
  // after the accept edge and retires when the response is consumed.
  bit          m_pending = 0;
  int          m_age     = 0;
  int          m_ptr     = 0;
  int          m_id      = 0;
  logic [31:0] m_op1     = '0;
  logic [31:0] m_op2     = '0;
  bit          m_sign    = 0;
  int          mw;
  bit          m_fire, m_can;

  function automatic int win(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic bit m_rsp();
    return m_pending && (m_age >= 1);
  endfunction

  function automatic logic [N-1:0] exp_ready();
    logic [N-1:0] r;
    int w;
    r = '0;
    w = win(req_valid, m_ptr);
    if ((!m_pending || (m_rsp() && rsp_ready)) && w >= 0) r[w] = 1'b1;
    return r;
  endfunction

  function automatic bit m_lss();
    if (m_sign) return $signed(m_op1) < $signed(m_op2);
    return m_op1 < m_op2;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_pending = 0;
      m_ptr     = 0;
      m_age     = 0;
    end else begin
      mw     = win(req_valid, m_ptr);
      m_fire = m_rsp() && rsp_ready;
      m_can  = !m_pending || m_fire;
      if (m_pending) m_age++;
      if (m_fire) m_pending = 0;
      if (m_can && mw >= 0) begin
        m_pending = 1;
        m_age     = 0;
        m_id      = mw;
        m_op1     = req_op1[32*mw +: 32];
        m_op2     = req_op2[32*mw +: 32];
        m_sign    = req_sign[mw];
        m_ptr     = (mw + 1) % N;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("req_ready", 32'(req_ready), 32'(exp_ready()));
      chk("rsp_valid", 32'(rsp_valid), 32'(m_rsp()));
      chk("busy", 32'(busy), 32'(m_pending));
      if (m_rsp()) begin
        chk("rsp_id", 32'(rsp_id), 32'(m_id));
        chk("rsp_eq", 32'(rsp_eq), 32'(m_op1 == m_op2));
        chk("rsp_neq", 32'(rsp_neq), 32'(m_op1 != m_op2));
        chk("rsp_lss", 32'(rsp_lss), 32'(m_lss()));
        chk("rsp_grt", 32'(rsp_grt), 32'((m_op1 != m_op2) && !m_lss()));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic single(input int id, input logic [31:0] a, input logic [31:0] b,
                        input bit s, input bit e_eq, input bit e_grt, input bit e_lss,
                        input bit mutate);
    logic [N-1:0] one;
    one = '0;
    one[id] = 1'b1;
    req_valid = one;
    req_op1[32*id +: 32] = a;
    req_op2[32*id +: 32] = b;
    req_sign[id] = s;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("single_grant", 32'(req_ready), 32'(one));
    tick();
    req_valid = '0;
    if (mutate) req_op1[32*id +: 32] = ~a;
    @(negedge clk);
    chk("single_cmp_no_rsp", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk("single_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("single_id", 32'(rsp_id), 32'(id));
    chk("single_eq", 32'(rsp_eq), 32'(e_eq));
    chk("single_neq", 32'(rsp_neq), 32'(!e_eq));
    chk("single_grt", 32'(rsp_grt), 32'(e_grt));
    chk("single_lss", 32'(rsp_lss), 32'(e_lss));
    tick();
    tick();
  endtask

  int order[$];
  int exp_order[5] = '{0, 1, 2, 3, 0};

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_op1   = '0;
    req_op2   = '0;
    req_sign  = '0;
    rsp_ready = 1'b0;
    do_reset();

    // reset state
    @(negedge clk);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_flags", 32'({rsp_eq, rsp_neq, rsp_grt, rsp_lss}), 32'd0);
    tick();

    // signed / unsigned / equal, and operand change after accept
    single(0, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    single(0, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    single(0, 32'h1234_5678, 32'h1234_5678, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    single(2, 32'd5, 32'd9, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    single(1, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    // all requesters continuously valid: round-robin order
    do_reset();
    req_valid = '1;
    rsp_ready = 1'b1;
    order.delete();
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) if (req_ready[i]) order.push_back(i);
      tick();
    end
    for (int i = 0; i < 5; i++)
      chk("rr_order", (i < order.size()) ? 32'(order[i]) : 32'hFFFF_FFFF, 32'(exp_order[i]));
    req_valid = '0;

    // backpressure in RESP, then back-to-back grant to the next requester
    do_reset();
    rsp_ready = 1'b0;
    req_valid = 4'b0001;
    tick();
    req_valid = 4'b1111;
    tick();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_no_ready", 32'(req_ready), 32'd0);
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      tick();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_grant", 32'(req_ready), 32'b0010);
    tick();
    req_valid = '0;
    tick();
    tick();
    tick();

    // reset while in CMP
    do_reset();
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req_valid = 4'b1111;
    @(negedge clk);
    chk("rstcmp_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rstcmp_busy", 32'(busy), 32'd0);
    chk("rstcmp_grant0", 32'(req_ready), 32'b0001);
    tick();
    req_valid = '0;
    tick();
    tick();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      req_valid = 4'($urandom);
      req_sign  = 4'($urandom);
      rsp_ready = ($urandom % 4) != 0;
      reset     = ($urandom % 150) == 0;
      for (int i = 0; i < N; i++) begin
        logic [31:0] a, b;
        case ($urandom % 4)
          0:       a = 32'h8000_0000;
          1:       a = 32'h7FFF_FFFF;
          default: a = $urandom;
        endcase
        b = (($urandom % 4) == 0) ? a : (($urandom % 5) == 0 ? 32'hFFFF_FFFF : $urandom);
        req_op1[32*i +: 32] = a;
        req_op2[32*i +: 32] = b;
      end
      tick();
    end
    reset     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
